// File: rtl/pdp8_pkg.sv
// Shared widths, pad output-enable codes and the external bus sequencer state encoding.
// Pure definitions: no logic, no latency, no flow control.
package pdp8_pkg;

    localparam int WORD_W = 12;
    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] OE_DRIVE = 8'hFF;
    localparam logic [BYTE_W-1:0] OE_FLOAT = 8'h00;

    typedef enum logic [3:0] {
        XB_IDLE,
        XB_ADR_LO,
        XB_ADR_HI,
        XB_WAIT,
        XB_W_LO,
        XB_W_HI,
        XB_R_LO,
        XB_R_HI,
        XB_DONE
    } xbus_state_t;

endpackage

// File: rtl/pdp8_xbus.sv
// Byte-serial external memory sequencer: ready 5+WAIT_CYCLES+E cycles after req is accepted.
// No queuing: req is only sampled in IDLE; ext_wait stretches the final WAIT cycle.
module pdp8_xbus
    import pdp8_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              ready,
    output logic [WORD_W-1:0] rdata,
    output logic              busy,
    output logic [BYTE_W-1:0] bus_out,
    output logic [BYTE_W-1:0] bus_oe,
    input  logic [BYTE_W-1:0] bus_in,
    output logic              ale,
    output logic              hi,
    output logic              rd,
    output logic              wr,
    input  logic              ext_wait
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    xbus_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    logic              ready_d, busy_d, ale_d, hi_d, rd_d, wr_d;
    logic [BYTE_W-1:0] bus_out_d, bus_oe_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            XB_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = XB_ADR_LO;
                end
            end
            XB_ADR_LO: state_d = XB_ADR_HI;
            XB_ADR_HI: begin
                cnt_d   = 4'd0;
                state_d = XB_WAIT;
            end
            XB_WAIT: begin
                // ext_wait only matters once the minimum wait has been served
                if (cnt_q != WAIT_LAST) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (!ext_wait) begin
                    cnt_d   = 4'd0;
                    state_d = we_q ? XB_W_LO : XB_R_LO;
                end
            end
            XB_W_LO: state_d = XB_W_HI;
            XB_W_HI: state_d = XB_DONE;
            XB_R_LO: state_d = XB_R_HI;
            XB_R_HI: state_d = XB_DONE;
            XB_DONE: state_d = XB_IDLE;
            default: state_d = XB_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        ready_d   = 1'b0;
        busy_d    = (state_d != XB_IDLE);
        ale_d     = 1'b0;
        hi_d      = 1'b0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        bus_out_d = '0;
        bus_oe_d  = OE_FLOAT;
        case (state_d)
            XB_ADR_LO: begin
                ale_d     = 1'b1;
                bus_oe_d  = OE_DRIVE;
                bus_out_d = addr_d[7:0];
            end
            XB_ADR_HI: begin
                ale_d     = 1'b1;
                hi_d      = 1'b1;
                bus_oe_d  = OE_DRIVE;
                bus_out_d = {we_d, 3'b000, addr_d[11:8]};
            end
            XB_W_LO: begin
                wr_d      = 1'b1;
                bus_oe_d  = OE_DRIVE;
                bus_out_d = wdata_d[7:0];
            end
            XB_W_HI: begin
                wr_d      = 1'b1;
                hi_d      = 1'b1;
                bus_oe_d  = OE_DRIVE;
                bus_out_d = {4'b0000, wdata_d[11:8]};
            end
            XB_R_LO: rd_d = 1'b1;
            XB_R_HI: begin
                rd_d = 1'b1;
                hi_d = 1'b1;
            end
            XB_DONE: ready_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= XB_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            ale     <= 1'b0;
            hi      <= 1'b0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            bus_out <= '0;
            bus_oe  <= OE_FLOAT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready   <= ready_d;
            busy    <= busy_d;
            ale     <= ale_d;
            hi      <= hi_d;
            rd      <= rd_d;
            wr      <= wr_d;
            bus_out <= bus_out_d;
            bus_oe  <= bus_oe_d;
            if (state_q == XB_R_LO)
                rdata[7:0] <= bus_in;
            if (state_q == XB_R_HI)
                rdata[11:8] <= 4'(bus_in & 8'h0F);
        end
    end

endmodule

// File: tb/tb_pdp8_xbus.sv
// Directed vector bench for pdp8_xbus: per-cycle pin tables plus a bounded ext_wait stretch check.
module tb_pdp8_xbus;

    logic        clk = 1'b0;
    logic        rst, req, we, ext_wait;
    logic [11:0] addr, wdata;
    logic [7:0]  bus_in;
    logic        ready, busy, ale, hi, rd, wr;
    logic [11:0] rdata;
    logic [7:0]  bus_out, bus_oe;

    int checks   = 0;
    int failures = 0;

    pdp8_xbus #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .busy(busy), .bus_out(bus_out), .bus_oe(bus_oe),
        .bus_in(bus_in), .ale(ale), .hi(hi), .rd(rd), .wr(wr), .ext_wait(ext_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          grp;
        logic        rst, req, we;
        logic [11:0] addr, wdata;
        logic [7:0]  bin;
        logic        ext;
        logic [5:0]  ctl;   // {ready, busy, ale, hi, rd, wr} after the edge
        logic [7:0]  oe, bout;
        logic [11:0] rdat;
    } vec_t;

    vec_t tbl[$];

    localparam logic [5:0] IDL = 6'b000000, ALO = 6'b011000, AHI = 6'b011100,
                           WT  = 6'b010000, WLO = 6'b010001, WHI = 6'b010101,
                           RLO = 6'b010010, RHI = 6'b010110, DN  = 6'b110000;

    function automatic void add(int g, logic r, logic q, logic w, logic [11:0] a, logic [11:0] d,
                                logic [7:0] b, logic e, logic [5:0] c, logic [7:0] o,
                                logic [7:0] bo, logic [11:0] rd_exp);
        vec_t v;
        v.grp = g; v.rst = r; v.req = q; v.we = w; v.addr = a; v.wdata = d;
        v.bin = b; v.ext = e; v.ctl = c; v.oe = o; v.bout = bo; v.rdat = rd_exp;
        tbl.push_back(v);
    endfunction

    logic [33:0] act, expv;
    int          got;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; bus_in = '0; ext_wait = 1'b0;

        // Reset state and idle
        add(0, 1, 0, 0, 12'h000, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'h000);
        add(0, 1, 1, 1, 12'hFFF, 12'hFFF, 8'hFF, 1, IDL, 8'h00, 8'h00, 12'h000);
        add(0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'h000);
        // Write FAC <- 29C
        add(1, 0, 1, 1, 12'hFAC, 12'h29C, 8'h00, 0, ALO, 8'hFF, 8'hAC, 12'h000);
        add(1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, AHI, 8'hFF, 8'h8F, 12'h000);
        add(1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'h000);
        add(1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'h000);
        add(1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WLO, 8'hFF, 8'h9C, 12'h000);
        add(1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WHI, 8'hFF, 8'h02, 12'h000);
        add(1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, DN,  8'h00, 8'h00, 12'h000);
        add(1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'h000);
        // Read 123, pads return 5A then F7
        add(2, 0, 1, 0, 12'h123, 12'h000, 8'h00, 0, ALO, 8'hFF, 8'h23, 12'h000);
        add(2, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, AHI, 8'hFF, 8'h01, 12'h000);
        add(2, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'h000);
        add(2, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'h000);
        add(2, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, RLO, 8'h00, 8'h00, 12'h000);
        add(2, 0, 0, 0, 12'h000, 12'h000, 8'h5A, 0, RHI, 8'h00, 8'h00, 12'h05A);
        add(2, 0, 0, 0, 12'h000, 12'h000, 8'hF7, 0, DN,  8'h00, 8'h00, 12'h75A);
        add(2, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'h75A);
        // Read 456 with ext_wait over the last counted WAIT cycle and two extensions
        add(3, 0, 1, 0, 12'h456, 12'h000, 8'h00, 0, ALO, 8'hFF, 8'h56, 12'h75A);
        add(3, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, AHI, 8'hFF, 8'h04, 12'h75A);
        add(3, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'h75A);
        add(3, 0, 0, 0, 12'h000, 12'h000, 8'h00, 1, WT,  8'h00, 8'h00, 12'h75A);
        add(3, 0, 0, 0, 12'h000, 12'h000, 8'h00, 1, WT,  8'h00, 8'h00, 12'h75A);
        add(3, 0, 0, 0, 12'h000, 12'h000, 8'h00, 1, WT,  8'h00, 8'h00, 12'h75A);
        add(3, 0, 0, 0, 12'h000, 12'h000, 8'h00, 1, WT,  8'h00, 8'h00, 12'h75A);
        add(3, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, RLO, 8'h00, 8'h00, 12'h75A);
        add(3, 0, 0, 0, 12'h000, 12'h000, 8'h33, 0, RHI, 8'h00, 8'h00, 12'h733);
        add(3, 0, 0, 0, 12'h000, 12'h000, 8'h4C, 0, DN,  8'h00, 8'h00, 12'hC33);
        add(3, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'hC33);
        // req held high: latched write to 0A5, then a read of 777 starts after the IDLE gap
        add(4, 0, 1, 1, 12'h0A5, 12'hABC, 8'h00, 0, ALO, 8'hFF, 8'hA5, 12'hC33);
        add(4, 0, 1, 0, 12'h777, 12'h000, 8'h00, 0, AHI, 8'hFF, 8'h80, 12'hC33);
        add(4, 0, 1, 0, 12'h777, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'hC33);
        add(4, 0, 1, 0, 12'h777, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'hC33);
        add(4, 0, 1, 0, 12'h777, 12'h000, 8'h00, 0, WLO, 8'hFF, 8'hBC, 12'hC33);
        add(4, 0, 1, 0, 12'h777, 12'h000, 8'h00, 0, WHI, 8'hFF, 8'h0A, 12'hC33);
        add(4, 0, 1, 0, 12'h777, 12'h000, 8'h00, 0, DN,  8'h00, 8'h00, 12'hC33);
        add(4, 0, 1, 0, 12'h777, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'hC33);
        add(4, 0, 1, 0, 12'h777, 12'h000, 8'h00, 0, ALO, 8'hFF, 8'h77, 12'hC33);
        add(4, 0, 0, 1, 12'h000, 12'h000, 8'h00, 0, AHI, 8'hFF, 8'h07, 12'hC33);
        add(4, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'hC33);
        add(4, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'hC33);
        add(4, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, RLO, 8'h00, 8'h00, 12'hC33);
        add(4, 0, 0, 0, 12'h000, 12'h000, 8'h11, 0, RHI, 8'h00, 8'h00, 12'hC11);
        add(4, 0, 0, 0, 12'h000, 12'h000, 8'h02, 0, DN,  8'h00, 8'h00, 12'h211);
        add(4, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'h211);
        // Reset in the second WAIT cycle of a write, then a clean read of 0FF
        add(5, 0, 1, 1, 12'h321, 12'h654, 8'h00, 0, ALO, 8'hFF, 8'h21, 12'h211);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, AHI, 8'hFF, 8'h83, 12'h211);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'h211);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'h211);
        add(5, 1, 0, 0, 12'h000, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'h000);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'h000);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'h000);
        add(5, 0, 1, 0, 12'h0FF, 12'h000, 8'h00, 0, ALO, 8'hFF, 8'hFF, 12'h000);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, AHI, 8'hFF, 8'h00, 12'h000);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'h000);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, WT,  8'h00, 8'h00, 12'h000);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, RLO, 8'h00, 8'h00, 12'h000);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'hA5, 0, RHI, 8'h00, 8'h00, 12'h0A5);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h3E, 0, DN,  8'h00, 8'h00, 12'hEA5);
        add(5, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0, IDL, 8'h00, 8'h00, 12'hEA5);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; req = tbl[i].req; we = tbl[i].we; addr = tbl[i].addr;
            wdata = tbl[i].wdata; bus_in = tbl[i].bin; ext_wait = tbl[i].ext;
            @(posedge clk);
            #1;
            act  = {ready, busy, ale, hi, rd, wr, bus_oe, bus_out, rdata};
            expv = {tbl[i].ctl, tbl[i].oe, tbl[i].bout, tbl[i].rdat};
            checks++;
            if (act !== expv) begin
                failures++;
                $display("FAIL vec grp=%0d idx=%0d got={rdy,bsy,ale,hi,rd,wr}=%b oe=%h out=%h rdata=%h want=%b oe=%h out=%h rdata=%h",
                         tbl[i].grp, i, act[33:28], act[27:20], act[19:12], act[11:0],
                         expv[33:28], expv[27:20], expv[19:12], expv[11:0]);
            end
        end

        // Long stall: ext_wait high through cycle 9, so WAIT ends at cycle 10 and ready lands at 13.
        got = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            req = (n == 0); we = 1'b0; addr = 12'hABC; bus_in = 8'hC6; ext_wait = (n < 10);
            @(posedge clk);
            #1;
            if (ready) begin
                got = n + 1;
                break;
            end
        end
        checks++;
        if (got != 13) begin
            failures++;
            $display("FAIL stall_ready_cycle got=%0d want=13 (-1 means no ready within bound)", got);
        end
        checks++;
        if (rdata !== 12'h6C6) begin
            failures++;
            $display("FAIL stall_rdata got=%h want=6c6", rdata);
        end
        @(negedge clk);
        ext_wait = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ready, busy} !== 2'b00) begin
            failures++;
            $display("FAIL stall_pulse_width got={ready,busy}=%b want=00", {ready, busy});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
